symbol_slicer_block: RTL and testbench

SYMBOL_SLICER_BLOCK -- requirements
Module: symbol_slicer_block

---
 rtl/symbol_slicer_block.sv | 139 +++++++++++++
 tb/tb_symbol_slicer_block.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/symbol_slicer_block.sv
// Symbol slicer: integrates N = 2^SPS_LOG2 samples per symbol and maps the sum onto
// four amplitude levels, with a one-entry holding slot when the output is still full.
module symbol_slicer_block #(
    parameter int SPS_LOG2 = 2
) (
    input  logic        ip_clock,
    input  logic        ip_reset,
    input  logic [11:0] ip_data,
    input  logic        ip_valid,
    input  logic [11:0] ip_data_2,
    output logic        op_ready,
    output logic [1:0]  op_data,
    output logic        op_valid,
    input  logic        ip_ready,
    output logic [7:0]  op_sym_count
);

    localparam int N  = 1 << SPS_LOG2;
    localparam int AW = 12 + SPS_LOG2;
    localparam int CW = 16 + SPS_LOG2;
    localparam logic [SPS_LOG2-1:0] CNT_LAST = SPS_LOG2'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic signed [AW-1:0]     acc_q, acc_d;
    logic [SPS_LOG2-1:0]      cnt_q, cnt_d;
    logic [11:0]              amp_q, amp_d;
    logic [1:0]               pending_q, pending_d;
    logic [1:0]               data_q, data_d;
    logic                     valid_q, valid_d;
    logic [7:0]               count_q, count_d;

    logic signed [AW-1:0]     sample_ext;
    logic signed [AW-1:0]     sum_w;
    logic signed [CW-1:0]     d_w, t_w, t3_w, t5_w;
    logic [1:0]               decision;

    assign sample_ext = {{SPS_LOG2{ip_data[11]}}, ip_data};
    assign sum_w      = acc_q + sample_ext;

    // D = 2*sum and T = A*N, both widened so 5T cannot reach the sign bit.
    assign d_w  = {{(CW-AW-1){sum_w[AW-1]}}, sum_w, 1'b0};
    assign t_w  = {{(CW-12-SPS_LOG2){1'b0}}, amp_q, {SPS_LOG2{1'b0}}};
    assign t3_w = t_w + {t_w[CW-2:0], 1'b0};
    assign t5_w = t_w + {t_w[CW-3:0], 2'b00};

    // Strict less-than pushes ties up to the higher symbol.
    always_comb begin
        decision = 2'd3;
        if (d_w < t_w)       decision = 2'd0;
        else if (d_w < t3_w) decision = 2'd1;
        else if (d_w < t5_w) decision = 2'd2;
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        amp_d     = amp_q;
        pending_d = pending_q;
        data_d    = data_q;
        valid_d   = valid_q;
        count_d   = count_q;

        if (valid_q && ip_ready) valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (ip_valid) begin
                    acc_d   = sample_ext;
                    amp_d   = ip_data_2;
                    cnt_d   = SPS_LOG2'(1);
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (ip_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (!valid_q || ip_ready) begin
                            data_d  = decision;
                            valid_d = 1'b1;
                            count_d = count_q + 8'd1;
                            state_d = IDLE;
                        end else begin
                            pending_d = decision;
                            state_d   = STALL;
                        end
                    end else begin
                        acc_d = sum_w;
                        cnt_d = cnt_q + SPS_LOG2'(1);
                    end
                end
            end
            STALL: begin
                if (ip_ready) begin
                    data_d  = pending_q;
                    valid_d = 1'b1;
                    count_d = count_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge ip_clock) begin
        if (ip_reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            amp_q     <= '0;
            pending_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            amp_q     <= amp_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
        end
    end

    assign op_ready     = (state_q != STALL);
    assign op_data      = data_q;
    assign op_valid     = valid_q;
    assign op_sym_count = count_q;

endmodule

// File: tb/tb_symbol_slicer_block.sv
// Bench for symbol_slicer_block (N=4): scenario tasks plus a scoreboard that pops
// expected symbols whenever the DUT hands one downstream.
module tb_symbol_slicer_block;

    logic        clk;
    logic        ip_reset;
    logic [11:0] ip_data;
    logic        ip_valid;
    logic [11:0] ip_data_2;
    logic        op_ready;
    logic [1:0]  op_data;
    logic        op_valid;
    logic        ip_ready;
    logic [7:0]  op_sym_count;

    int          checks;
    int          failures;
    int          mon_pops;
    logic        mon_en;
    logic [7:0]  exp_count;
    logic [1:0]  exp_q[$];

    symbol_slicer_block #(.SPS_LOG2(2)) dut (
        .ip_clock    (clk),
        .ip_reset    (ip_reset),
        .ip_data     (ip_data),
        .ip_valid    (ip_valid),
        .ip_data_2   (ip_data_2),
        .op_ready    (op_ready),
        .op_data     (op_data),
        .op_valid    (op_valid),
        .ip_ready    (ip_ready),
        .op_sym_count(op_sym_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A symbol is consumed on the falling edge where op_valid and ip_ready are both high.
    always begin
        @(posedge clk);
        #2;
        if (mon_en && !ip_reset && op_valid === 1'b1 && ip_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got op_data=%0d with no symbol expected", op_data);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                mon_pops++;
                if (op_data !== e) begin
                    failures++;
                    $display("FAIL sb_symbol: op_data=%0d expected=%0d", op_data, e);
                end
            end
        end
    end

    function automatic logic [1:0] model_dec(input int sum, input int a);
        int d, t;
        d = 2 * sum;
        t = a * 4;
        if (d < t)          return 2'd0;
        else if (d < 3 * t) return 2'd1;
        else if (d < 5 * t) return 2'd2;
        else                return 2'd3;
    endfunction

    task automatic send_sample(input int d, input int a, input int gap);
        int guard;
        repeat (gap) begin
            @(posedge clk);
            #1;
            ip_valid  = 1'b0;
            ip_data_2 = 12'($urandom_range(0, 4095));
        end
        @(posedge clk);
        #1;
        ip_valid  = 1'b1;
        ip_data   = d[11:0];
        ip_data_2 = a[11:0];
        guard = 0;
        while (op_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: op_ready=%b expected=1", op_ready);
        end
        @(negedge clk);
        #1;
        ip_valid = 1'b0;
    endtask

    task automatic send_symbol(input int s0, input int s1, input int s2, input int s3,
                               input int a, input int a_alt, input int max_gap);
        exp_q.push_back(model_dec(s0 + s1 + s2 + s3, a));
        exp_count = exp_count + 8'd1;
        send_sample(s0, a, $urandom_range(0, max_gap));
        send_sample(s1, a_alt, $urandom_range(0, max_gap));
        send_sample(s2, a_alt, $urandom_range(0, max_gap));
        send_sample(s3, a_alt, $urandom_range(0, max_gap));
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        ip_reset = 1'b1;
        ip_valid = 1'b1;
        ip_data  = 12'd777;
        @(negedge clk);
        #1;
        ip_reset = 1'b0;
        ip_valid = 1'b0;
        exp_q.delete();
        exp_count = 8'd0;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (op_valid !== 1'b0 || op_data !== 2'd0 || op_sym_count !== 8'd0 || op_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s: valid=%b data=%0d count=%0d ready=%b expected 0/0/0/1",
                     tag, op_valid, op_data, op_sym_count, op_ready);
        end
    endtask

    task automatic test_reset();
        ip_reset  = 1'b1;
        ip_valid  = 1'b1;
        ip_data   = 12'd123;
        ip_data_2 = 12'd5;
        ip_ready  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        ip_reset = 1'b0;
        ip_valid = 1'b0;
        exp_count = 8'd0;
        check_idle_outputs("reset_state");
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        ip_ready = 1'b1;
        exp_q.push_back(2'd2);
        exp_count = exp_count + 8'd1;
        send_sample(200, 100, 0);
        send_sample(200, 100, 0);
        send_sample(200, 100, 0);
        checks++;
        if (op_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early: op_valid=%b expected=0 before 4th sample", op_valid);
        end
        send_sample(200, 100, 0);
        checks++;
        if (op_valid !== 1'b1 || op_data !== 2'd2 || op_sym_count !== 8'd1) begin
            failures++;
            $display("FAIL basic_decision: valid=%b data=%0d count=%0d expected 1/2/1",
                     op_valid, op_data, op_sym_count);
        end
    endtask

    task automatic test_thresholds();
        send_symbol(50, 50, 50, 50, 100, 100, 0);
        send_symbol(-50, -50, -50, -50, 100, 100, 0);
        send_symbol(2047, 2047, 2047, 2047, 100, 100, 0);
        send_symbol(100, 100, 100, 100, 100, 100, 0);
        send_symbol(0, 0, 0, 0, 0, 0, 0);
        send_symbol(-1, 0, 0, 0, 0, 0, 0);
        send_symbol(149, 151, 150, 150, 100, 100, 0);
        send_symbol(249, 250, 250, 250, 100, 100, 0);
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (op_sym_count !== exp_count) begin
            failures++;
            $display("FAIL thresh_count: count=%0d expected=%0d", op_sym_count, exp_count);
        end
    endtask

    task automatic test_stall();
        @(posedge clk);
        #1;
        ip_ready = 1'b0;
        send_symbol(200, 200, 200, 200, 100, 100, 0);
        send_symbol(300, 300, 300, 300, 100, 100, 0);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (op_ready !== 1'b0 || op_valid !== 1'b1 || op_data !== 2'd2 ||
            op_sym_count !== exp_count - 8'd1) begin
            failures++;
            $display("FAIL stall_hold: ready=%b valid=%b data=%0d count=%0d expected 0/1/2/%0d",
                     op_ready, op_valid, op_data, op_sym_count, exp_count - 8'd1);
        end
        @(posedge clk);
        #1;
        ip_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (op_valid !== 1'b1 || op_data !== 2'd3 || op_sym_count !== exp_count || op_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: valid=%b data=%0d count=%0d ready=%b expected 1/3/%0d/1",
                     op_valid, op_data, op_sym_count, op_ready, exp_count);
        end
        @(negedge clk);
        #1;
        checks++;
        if (op_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_drain: op_valid=%b expected=0", op_valid);
        end
    endtask

    task automatic test_gaps();
        for (int k = 0; k < 12; k++) begin
            int s0, s1, s2, s3, a;
            s0 = int'($urandom_range(0, 4095)) - 2048;
            s1 = int'($urandom_range(0, 4095)) - 2048;
            s2 = int'($urandom_range(0, 4095)) - 2048;
            s3 = int'($urandom_range(0, 4095)) - 2048;
            a  = int'($urandom_range(0, 1500));
            send_symbol(s0, s1, s2, s3, a, int'($urandom_range(0, 4095)), 5);
        end
        send_symbol(200, 200, 200, 200, 100, 4095, 5);
        send_symbol(50, 50, 50, 50, 100, 0, 5);
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (op_sym_count !== exp_count || exp_q.size() != 0) begin
            failures++;
            $display("FAIL gaps_drain: count=%0d expected=%0d pending=%0d expected=0",
                     op_sym_count, exp_count, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        send_sample(2000, 100, 0);
        send_sample(2000, 100, 0);
        apply_reset();
        check_idle_outputs("reset_mid");
        exp_q.push_back(2'd1);
        exp_count = exp_count + 8'd1;
        send_sample(100, 100, 0);
        send_sample(100, 100, 0);
        send_sample(100, 100, 0);
        send_sample(100, 100, 0);
        checks++;
        if (op_valid !== 1'b1 || op_data !== 2'd1 || op_sym_count !== 8'd1) begin
            failures++;
            $display("FAIL reset_mid_next: valid=%b data=%0d count=%0d expected 1/1/1",
                     op_valid, op_data, op_sym_count);
        end
    endtask

    task automatic test_back_to_back();
        int pops_start;
        repeat (2) @(posedge clk);
        apply_reset();
        pops_start = mon_pops;
        for (int k = 1; k <= 257; k++) begin
            send_symbol(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                        int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                        int'($urandom_range(0, 2000)), int'($urandom_range(0, 4095)), 0);
            if (k == 255 || k == 256) begin
                checks++;
                if (op_sym_count !== exp_count) begin
                    failures++;
                    $display("FAIL wrap_count_%0d: count=%0d expected=%0d", k, op_sym_count, exp_count);
                end
            end
        end
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (op_sym_count !== 8'd1 || mon_pops - pops_start != 257 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_final: count=%0d expected=1 pops=%0d expected=257 pending=%0d expected=0",
                     op_sym_count, mon_pops - pops_start, exp_q.size());
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        mon_pops  = 0;
        mon_en    = 1'b0;
        exp_count = 8'd0;
        test_reset();
        test_basic();
        test_thresholds();
        test_stall();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
